// File: rtl/ks_pkg.sv
// Shared definitions for the iterative Kogge-Stone adder: default width,
// prefix depth and FSM state encoding.
package ks_pkg;

  localparam int KS_WIDTH  = 16;
  localparam int KS_LEVELS = $clog2(KS_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PREFIX = 2'd1,
    ST_DONE   = 2'd2
  } ks_state_t;

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone group combine: merges bit/group (P, G) with the group that
// sits one span below it.
module ks_prefix_cell (
  input  logic i_p,
  input  logic i_g,
  input  logic i_p_prev,
  input  logic i_g_prev,
  output logic o_p,
  output logic o_g
);

  // A group generates if it generates on its own, or propagates a carry
  // generated by the lower group.
  always_comb begin
    o_g = i_g | (i_p & i_g_prev);
    o_p = i_p & i_p_prev;
  end

endmodule

// File: rtl/ks_iter_adder.sv
// Iterative Kogge-Stone adder/subtractor. One prefix level is evaluated per
// clock over a WIDTH-wide (G, P) register bank, so the full carry tree
// takes LEVELS cycles.
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// PREFIX | evaluating prefix level lvl (span 2^lvl)
// DONE   | result held on outputs until out_ready
module ks_iter_adder
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int LVL_W  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(LEVELS - 1);

  ks_state_t         r_state;
  ks_state_t         w_state_nxt;
  logic [LVL_W-1:0]  r_lvl;
  logic [WIDTH-1:0]  r_g;
  logic [WIDTH-1:0]  r_p;
  logic [WIDTH-1:0]  r_p_orig;
  logic              r_c0;
  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_bx;
  logic              w_c0;
  logic [WIDTH-1:0]  w_p_in;
  logic [WIDTH-1:0]  w_g_in;
  logic [LEVELS-1:0] w_gsel [WIDTH];
  logic [LEVELS-1:0] w_psel [WIDTH];
  logic [LEVELS-1:0] w_act  [WIDTH];
  logic [WIDTH-1:0]  w_g_cell;
  logic [WIDTH-1:0]  w_p_cell;
  logic [WIDTH-1:0]  w_g_nxt;
  logic [WIDTH-1:0]  w_p_nxt;
  logic              w_last;

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  assign w_last = (r_lvl == LVL_LAST);

  // Operand conditioning: subtraction inverts b and forces carry-in, and the
  // carry-in is folded into bit 0's generate so the prefix tree needs no
  // separate carry input.
  always_comb begin
    w_bx      = sub ? ~b : b;
    w_c0      = sub ? 1'b1 : cin;
    w_p_in    = a ^ w_bx;
    w_g_in    = a & w_bx;
    w_g_in[0] = w_g_in[0] | (w_p_in[0] & w_c0);
  end

  // Per-bit span selection: every candidate span is wired up at elaboration
  // time and the current level picks one; bits below the span bypass.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    for (genvar k = 0; k < LEVELS; k++) begin : g_span
      if (i >= (2 ** k)) begin : g_src
        assign w_gsel[i][k] = r_g[i - (2 ** k)];
        assign w_psel[i][k] = r_p[i - (2 ** k)];
        assign w_act[i][k]  = 1'b1;
      end else begin : g_none
        assign w_gsel[i][k] = 1'b0;
        assign w_psel[i][k] = 1'b0;
        assign w_act[i][k]  = 1'b0;
      end
    end

    ks_prefix_cell u_cell (
      .i_p      (r_p[i]),
      .i_g      (r_g[i]),
      .i_p_prev (w_psel[i][r_lvl]),
      .i_g_prev (w_gsel[i][r_lvl]),
      .o_p      (w_p_cell[i]),
      .o_g      (w_g_cell[i])
    );

    assign w_g_nxt[i] = w_act[i][r_lvl] ? w_g_cell[i] : r_g[i];
    assign w_p_nxt[i] = w_act[i][r_lvl] ? w_p_cell[i] : r_p[i];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_state_nxt = ST_PREFIX;
      ST_PREFIX: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:   if (out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one prefix level per cycle, result load on
  // the final level. After the last level G[i] is the carry out of bit i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl    <= '0;
      r_g      <= '0;
      r_p      <= '0;
      r_p_orig <= '0;
      r_c0     <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_g      <= w_g_in;
            r_p      <= w_p_in;
            r_p_orig <= w_p_in;
            r_c0     <= w_c0;
            r_lvl    <= '0;
          end
        end
        ST_PREFIX: begin
          r_g <= w_g_nxt;
          r_p <= w_p_nxt;
          if (w_last) begin
            r_lvl  <= '0;
            r_sum  <= r_p_orig ^ {w_g_nxt[WIDTH-2:0], r_c0};
            r_cout <= w_g_nxt[WIDTH-1];
            r_ovf  <= w_g_nxt[WIDTH-2] ^ w_g_nxt[WIDTH-1];
          end else begin
            r_lvl <= r_lvl + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ks_iter_adder.sv
// Bench for ks_iter_adder: directed vector table, backpressure and reset
// abort sequences, then random traffic against an integer-arithmetic model.
module tb_ks_iter_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  ks_iter_adder #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow,
  // unsigned compare for borrow.
  function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                input logic mcin, input logic msub,
                                output logic [15:0] s, output logic co, output logic ov);
    longint u;
    int     r;
    int     sa;
    int     sb;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (msub) begin
      u  = longint'(ma) - longint'(mb);
      co = (ma >= mb);
      r  = sa - sb;
    end else begin
      u  = longint'(ma) + longint'(mb) + longint'(mcin);
      co = (u > 65535);
      r  = sa + sb + int'(mcin);
    end
    s  = u[15:0];
    ov = (r > 32767) || (r < -32768);
  endfunction

  // Waits for in_ready, transfers one operand set, waits for out_valid and
  // returns the result plus the accept-to-valid latency. Caller releases.
  task automatic start_and_wait(input logic [15:0] ta, input logic [15:0] tb,
                                input logic tcin, input logic tsub,
                                output int lat, output bit timed_out);
    int n;
    timed_out = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      timed_out = 1'b1;
      lat = -1;
      return;
    end
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) timed_out = 1'b1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] es;
    logic        ec;
    logic        eo;
    logic [15:0] held_s;
    logic        held_c;
    logic        held_o;
    int          lat;
    bit          to;
    bit          stable;
    bit          seen_valid;

    vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
    vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
    vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_outputs", {15'd0, sum, cout, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Directed table
    foreach (vecs[i]) begin
      start_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, to);
      check($sformatf("vec%0d_timeout", i), {31'd0, to}, 32'd0);
      check($sformatf("vec%0d_latency", i), lat, 32'd4);
      check($sformatf("vec%0d_result", i), {14'd0, sum, cout, ovf},
            {14'd0, vecs[i].sum, vecs[i].cout, vecs[i].ovf});
      release_result();
    end

    // Backpressure: result held, no accept while DONE
    start_and_wait(16'h1111, 16'h2222, 1'b0, 1'b0, lat, to);
    check("bp_timeout", {31'd0, to}, 32'd0);
    held_s = sum; held_c = cout; held_o = ovf;
    stable = 1'b1;
    in_valid = 1'b1; a = 16'h0F0F; b = 16'h0F0F;
    repeat (10) begin
      @(posedge clk); #1;
      if (sum !== held_s || cout !== held_c || ovf !== held_o ||
          in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
    end
    check("bp_held_stable", {31'd0, stable}, 32'd1);
    check("bp_result", {15'd0, held_s, held_c, held_o}, {15'd0, 16'h3333, 1'b0, 1'b0});
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_in_ready_after_release", {31'd0, in_ready}, 32'd1);
    check("bp_out_valid_after_release", {31'd0, out_valid}, 32'd0);

    // Reset on the E2 cycle aborts the operation
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (8) begin
      if (out_valid) seen_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("abort_no_valid", {31'd0, seen_valid}, 32'd0);
    check("abort_outputs_zero", {15'd0, sum, cout, ovf}, 32'd0);
    start_and_wait(16'h1234, 16'h4321, 1'b0, 1'b0, lat, to);
    check("after_abort_timeout", {31'd0, to}, 32'd0);
    check("after_abort_result", {15'd0, sum, cout, ovf}, {15'd0, 16'h5555, 1'b0, 1'b0});
    release_result();

    // Random traffic with random backpressure
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic        rs;
      ra = $urandom; rb = $urandom; rc = $urandom; rs = $urandom;
      if (n == 5) begin ra = 16'h8000; rb = 16'h0001; rs = 1'b1; end
      model(ra, rb, rc, rs, es, ec, eo);
      start_and_wait(ra, rb, rc, rs, lat, to);
      check($sformatf("rnd%0d a=%h b=%h cin=%0d sub=%0d", n, ra, rb, rc, rs),
            {13'd0, to, lat == 4, sum, cout, ovf},
            {13'd0, 1'b0, 1'b1, es, ec, eo});
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      release_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
